// File: rtl/alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_issue_stage: RV32I ALU decode/issue with a 2-entry skid buffer        |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [5:0]      ALU_Control,
  output logic [XLEN-1:0] operand_A,
  output logic [XLEN-1:0] operand_B,
  output logic            illegal
);

  typedef struct packed {
    logic [5:0]      ctrl;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            ill;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, shamt, pc_plus4;
  logic            bad;
  entry_t          dec;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7   = instruction[31:25];
  assign imm_i    = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s    = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_u    = {instruction[31:12], 12'b0};
  assign shamt    = {27'b0, instruction[24:20]};
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    dec = '0;
    bad = 1'b0;
    case (opcode)
      OPC_LUI:   dec.b = imm_u;
      OPC_AUIPC: begin dec.a = pc;       dec.b = imm_u; end
      OPC_LOAD:  begin dec.a = rs1_data; dec.b = imm_i; end
      OPC_STORE: begin dec.a = rs1_data; dec.b = imm_s; end
      OPC_OPIMM: begin
        dec.a    = rs1_data;
        dec.b    = imm_i;
        dec.ctrl = {3'b000, funct3};
        if (funct3 == 3'b001) begin
          dec.b = shamt;
          bad   = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          dec.b = shamt;
          if (funct7 == F7_ALT) dec.ctrl = {3'b001, funct3};
          else                  bad      = (funct7 != F7_ZERO);
        end
      end
      OPC_OP: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        // Alternate funct7 is only meaningful for SUB and SRA.
        if (funct7 == F7_ZERO)
          dec.ctrl = {3'b000, funct3};
        else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
          dec.ctrl = {3'b001, funct3};
        else
          bad = 1'b1;
      end
      OPC_BRANCH: begin
        dec.a = rs1_data;
        dec.b = rs2_data;
        case (funct3)
          3'b000:  dec.ctrl = 6'b010000;
          3'b001:  dec.ctrl = 6'b010001;
          3'b100:  dec.ctrl = 6'b000010;
          3'b101:  dec.ctrl = 6'b010101;
          3'b110:  dec.ctrl = 6'b010110;
          3'b111:  dec.ctrl = 6'b010111;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin dec.ctrl = 6'b011111; dec.a = pc_plus4; end
      OPC_JALR: begin
        dec.ctrl = 6'b111111;
        dec.a    = pc_plus4;
        bad      = (funct3 != 3'b000);
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  state_e state_q, state_d;
  entry_t head_q, head_d, skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   push, pop;

  assign out_valid   = (state_q != EMPTY);
  assign in_ready    = in_ready_q;
  assign push        = in_valid & in_ready_q;
  assign pop         = out_valid & out_ready;
  assign ALU_Control = head_q.ctrl;
  assign operand_A   = head_q.a;
  assign operand_B   = head_q.b;
  assign illegal     = head_q.ill;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) begin head_d = dec; state_d = ONE; end
        ONE: begin
          if (push && pop)  head_d = dec;
          else if (push)    begin skid_d = dec; state_d = FULL; end
          else if (pop)     state_d = EMPTY;
        end
        FULL: if (pop) begin head_d = skid_q; state_d = ONE; end
        default: state_d = EMPTY;
      endcase
    end
    // Ready is registered from the next state so it never depends on out_ready.
    in_ready_d = (state_d != FULL);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_issue_stage: directed vector bench for alu_issue_stage             |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, illegal;
  logic [31:0] instruction, pc, rs1_data, rs2_data, operand_A, operand_B;
  logic [5:0]  ALU_Control;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  alu_issue_stage #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
    .illegal(illegal)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    instruction = ins;
    pc          = p;
    rs1_data    = r1;
    rs2_data    = r2;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF10093, 32'h0,        32'h5,        32'h0,    6'h00, 32'h5,        32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{32'h12345097, 32'h100,      32'h0,        32'h0,    6'h00, 32'h100,      32'h12345000, 1'b0};
    vecs[2]  = '{32'h0000006F, 32'hFFFFFFFC, 32'h0,        32'h0,    6'h1F, 32'h0,        32'h0,        1'b0};
    vecs[3]  = '{32'h12345037, 32'h200,      32'hDEADBEEF, 32'h0,    6'h00, 32'h0,        32'h12345000, 1'b0};
    vecs[4]  = '{32'h402081B3, 32'h0,        32'h10,       32'h3,    6'h08, 32'h10,       32'h3,        1'b0};
    vecs[5]  = '{32'h4040D093, 32'h0,        32'h80000000, 32'h0,    6'h0D, 32'h80000000, 32'h4,        1'b0};
    vecs[6]  = '{32'h0240D093, 32'h40,       32'h80000000, 32'h7,    6'h00, 32'h0,        32'h0,        1'b1};
    vecs[7]  = '{32'h0000007F, 32'h44,       32'h11,       32'h22,   6'h00, 32'h0,        32'h0,        1'b1};
    vecs[8]  = '{32'h0020E063, 32'h0,        32'hAAAA,     32'hBBBB, 6'h16, 32'hAAAA,     32'hBBBB,     1'b0};
    vecs[9]  = '{32'hFE20AE23, 32'h0,        32'h1000,     32'h55,   6'h00, 32'h1000,     32'hFFFFFFFC, 1'b0};
    vecs[10] = '{32'h00008067, 32'h1000,     32'h7,        32'h0,    6'h3F, 32'h1004,     32'h0,        1'b0};
    vecs[11] = '{32'h00009067, 32'h1000,     32'h7,        32'h0,    6'h00, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{32'h7FF13093, 32'h0,        32'h9,        32'h0,    6'h03, 32'h9,        32'h7FF,      1'b0};
    vecs[13] = '{32'h40209133, 32'h0,        32'h1,        32'h2,    6'h00, 32'h0,        32'h0,        1'b1};
    vecs[14] = '{32'h0020D063, 32'h0,        32'h3,        32'h4,    6'h15, 32'h3,        32'h4,        1'b0};
    vecs[15] = '{32'h00812083, 32'h0,        32'h20,       32'h0,    6'h00, 32'h20,       32'h8,        1'b0};
    vecs[16] = '{32'h00209133, 32'h0,        32'h6,        32'h2,    6'h01, 32'h6,        32'h2,        1'b0};

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0);
    tick; tick;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'h1);
    chk("rst_ctrl",      {26'b0, ALU_Control}, 32'h0);
    chk("rst_opA",       operand_A, 32'h0);
    chk("rst_opB",       operand_B, 32'h0);
    chk("rst_illegal",   {31'b0, illegal}, 32'h0);
    reset = 1'b1;

    // Streaming: one entry per cycle, each replacing the previous head.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      tick;
      chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("vec%0d_ctrl", i),  {26'b0, ALU_Control}, {26'b0, vecs[i].ctrl});
      chk($sformatf("vec%0d_opA", i),   operand_A, vecs[i].a);
      chk($sformatf("vec%0d_opB", i),   operand_B, vecs[i].b);
      chk($sformatf("vec%0d_ill", i),   {31'b0, illegal}, {31'b0, vecs[i].ill});
    end
    in_valid = 1'b0;
    tick;
    chk("drain_empty", {31'b0, out_valid}, 32'h0);

    // Back-pressure: three pushes, only two fit.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'hFFF10093, 32'h0, 32'h111, 32'h0);
    tick;
    chk("skid_first_valid", {31'b0, out_valid}, 32'h1);
    chk("skid_ready_one",   {31'b0, in_ready},  32'h1);
    drive(32'hFFF10093, 32'h0, 32'h222, 32'h0);
    tick;
    chk("skid_ready_full",  {31'b0, in_ready},  32'h0);
    chk("skid_head_hold1",  operand_A, 32'h111);
    drive(32'hFFF10093, 32'h0, 32'h333, 32'h0);
    tick;
    chk("skid_head_hold2",  operand_A, 32'h111);
    chk("skid_ready_still", {31'b0, in_ready},  32'h0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("skid_second_valid", {31'b0, out_valid}, 32'h1);
    chk("skid_second_A",     operand_A, 32'h222);
    chk("skid_ready_back",   {31'b0, in_ready},  32'h1);
    tick;
    chk("skid_no_third", {31'b0, out_valid}, 32'h0);

    // Flush while full with a same-cycle input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(32'hFFF10093, 32'h0, 32'hA1, 32'h0);
    tick;
    drive(32'hFFF10093, 32'h0, 32'hA2, 32'h0);
    tick;
    chk("flush_pre_full", {31'b0, in_ready}, 32'h0);
    flush = 1'b1;
    drive(32'hFFF10093, 32'h0, 32'hA3, 32'h0);
    tick;
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    chk("flush_in_ready",  {31'b0, in_ready},  32'h1);
    flush    = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("flush_dropped", {31'b0, out_valid}, 32'h0);

    // Reset while full.
    in_valid = 1'b1;
    drive(32'hFFF10093, 32'h0, 32'hB1, 32'h0);
    tick;
    drive(32'hFFF10093, 32'h0, 32'hB2, 32'h0);
    tick;
    chk("rstfull_pre", {31'b0, in_ready}, 32'h0);
    in_valid = 1'b0;
    reset    = 1'b0;
    tick;
    chk("rstfull_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rstfull_in_ready",  {31'b0, in_ready},  32'h1);
    chk("rstfull_opA",       operand_A, 32'h0);
    reset     = 1'b1;
    out_ready = 1'b1;
    tick;
    chk("rstfull_stay_empty", {31'b0, out_valid}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
